// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, pixel/coordinate types and the test-pattern
// bar decoder for the VGA scan driver.
//   H_*_DEF / V_*_DEF : default 640x480@60 timing (pixels / lines)
//   H_TOTAL / V_TOTAL : derived totals for the default timing
//   coord_t           : 10-bit raster coordinate
//   rgb_t             : 8-bit-per-channel colour
//   bar_index()       : column -> vertical bar number (0..7)
package vga_pkg;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Comparison ladder instead of a divider; columns past the last bar
    // saturate at 7 (they are always blanked anyway).
    function automatic logic [2:0] bar_index(input coord_t col, input int unsigned bar_w);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (col >= coord_t'(i * bar_w)) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register advanced only when ce is high.
// DEPTH = 0 degenerates to a direct wire.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, loads RESET_VAL into every stage
//   ce      : shift enable
//   d_i     : data in
//   q_o     : data delayed by DEPTH enabled cycles
module vga_delay_line #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ce,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = clk_i ^ rst_ni ^ ce;
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
                end else if (ce) begin
                    stage_q[0] <= d_i;
                    for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: raster timing generator and registered VGA DAC driver.
// Presents DrawX/DrawY to the colour mapper, accepts Red/Green/Blue_in
// PIPE_LAT pix_ce ticks later, and registers colour, sync and blank together.
//   Clk, Reset_n         : 50 MHz clock, async active-low reset
//   pix_ce               : one-Clk pixel enable (25 MHz rate)
//   pattern_sel          : selects colour-bar test pattern (VGA_TEST_PATTERN_EN only)
//   Red/Green/Blue_in    : colour for the pixel presented PIPE_LAT ticks earlier
//   DrawX, DrawY         : current raster position
//   VGA_R/G/B            : registered colour, zero while blanked
//   VGA_HS, VGA_VS       : active-low syncs
//   VGA_BLANK_N          : low while blanked
//   VGA_SYNC_N           : tied low
//   frame_start          : one-Clk pulse when the raster wraps to (0,0)
// Optional build macro: VGA_TEST_PATTERN_EN adds the 8-bar test pattern.
module vga_scan_driver
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter int unsigned PIPE_LAT  = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       pix_ce,
    input  logic       pattern_sel,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_start
);

    localparam int unsigned H_LEN = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_LEN = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_LEN - 1);
    localparam coord_t V_LAST   = coord_t'(V_LEN - 1);
    localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // ---------------- raster counters ----------------
    coord_t hc_q, hc_d, vc_q, vc_d;
    logic   h_wrap, v_wrap;
    logic   frame_start_q, frame_start_d;

    always_comb begin
        h_wrap        = (hc_q == H_LAST);
        v_wrap        = (vc_q == V_LAST);
        hc_d          = h_wrap ? '0 : hc_q + 10'd1;
        vc_d          = vc_q;
        if (h_wrap) vc_d = v_wrap ? '0 : vc_q + 10'd1;
        frame_start_d = pix_ce & h_wrap & v_wrap;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hc_q <= '0;
            vc_q <= '0;
        end else if (pix_ce) begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Pulse register runs every Clk so the pulse is exactly one Clk wide.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) frame_start_q <= 1'b0;
        else          frame_start_q <= frame_start_d;
    end

    // ---------------- per-position terms ----------------
    logic hs_n, vs_n, act;

    always_comb begin
        hs_n = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
        vs_n = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
        act  = (hc_q < coord_t'(H_VISIBLE)) && (vc_q < coord_t'(V_VISIBLE));
    end

    // ---------------- alignment delay line ----------------
`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DL_W = 13;
    logic [DL_W-1:0] dl_in, dl_out;
    coord_t          col_dly;
    logic [2:0]      bar;
    assign dl_in   = {hc_q, hs_n, vs_n, act};
    assign col_dly = dl_out[12:3];
    assign bar     = bar_index(col_dly, H_VISIBLE / 8);
`else
    localparam int unsigned DL_W = 3;
    logic [DL_W-1:0] dl_in, dl_out;
    logic            unused_pattern_sel;
    assign dl_in              = {hs_n, vs_n, act};
    assign unused_pattern_sel = pattern_sel;
`endif

    localparam logic [DL_W-1:0] DL_RST = DL_W'(3'b110);

    vga_delay_line #(
        .WIDTH     (DL_W),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL (DL_RST)
    ) u_align (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .ce     (pix_ce),
        .d_i    (dl_in),
        .q_o    (dl_out)
    );

    logic hs_dly, vs_dly, act_dly;
    assign {hs_dly, vs_dly, act_dly} = dl_out[2:0];

    // ---------------- colour source ----------------
    rgb_t src_rgb;

    always_comb begin
        src_rgb = '{r: Red_in, g: Green_in, b: Blue_in};
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_sel) begin
            src_rgb = '{r: {8{bar[2]}}, g: {8{bar[1]}}, b: {8{bar[0]}}};
        end
`endif
    end

    // ---------------- output register ----------------
    rgb_t rgb_q;
    logic hs_q, vs_q, blank_n_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else if (pix_ce) begin
            rgb_q     <= act_dly ? src_rgb : '0;
            hs_q      <= hs_dly;
            vs_q      <= vs_dly;
            blank_n_q <= act_dly;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: directed, table-driven bench for vga_scan_driver.
// dut   : default timing, PIPE_LAT = 1, constant colour inputs.
// dut_s : default horizontal timing, 6-line frame, PIPE_LAT = 2, colour
//         inputs fed from DrawX/DrawY delayed two pix_ce ticks.
module tb_vga_scan_driver;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_ce;
    logic psel;

    always #5 clk = ~clk;

    // ---------------- dut: default configuration ----------------
    logic [7:0] red_m, grn_m, blu_m;
    logic [9:0] x_m, y_m;
    logic [7:0] r_m, g_m, b_m;
    logic       hs_m, vs_m, bl_m, sn_m, fs_m;

    vga_scan_driver dut (
        .Clk(clk), .Reset_n(rst_n), .pix_ce(pix_ce), .pattern_sel(psel),
        .Red_in(red_m), .Green_in(grn_m), .Blue_in(blu_m),
        .DrawX(x_m), .DrawY(y_m), .VGA_R(r_m), .VGA_G(g_m), .VGA_B(b_m),
        .VGA_HS(hs_m), .VGA_VS(vs_m), .VGA_BLANK_N(bl_m), .VGA_SYNC_N(sn_m),
        .frame_start(fs_m)
    );

    // ---------------- dut_s: short frame, PIPE_LAT = 2 ----------------
    localparam int S_VV = 2, S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int S_FRAME = 800 * (S_VV + S_VF + S_VS + S_VB);

    logic       psel_s;
    logic [9:0] x_s, y_s;
    logic [7:0] r_s, g_s, b_s;
    logic       hs_s, vs_s, bl_s, sn_s, fs_s;
    logic [9:0] px1, px2, py1, py2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px1 <= '0; px2 <= '0; py1 <= '0; py2 <= '0;
        end else if (pix_ce) begin
            px1 <= x_s; px2 <= px1;
            py1 <= y_s; py2 <= py1;
        end
    end

    vga_scan_driver #(
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .PIPE_LAT(2)
    ) dut_s (
        .Clk(clk), .Reset_n(rst_n), .pix_ce(pix_ce), .pattern_sel(psel_s),
        .Red_in(px2[7:0]), .Green_in(py2[7:0]), .Blue_in(~px2[7:0]),
        .DrawX(x_s), .DrawY(y_s), .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s),
        .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(bl_s), .VGA_SYNC_N(sn_s),
        .frame_start(fs_s)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    int n = 0;          // pix_ce ticks since reset release
    int fs_cnt = 0;
    int hs_run = 0;
    int vs_run = 0;
    logic fs_prev = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s (tick %0d): got %0d, expected %0d", name, n, got, exp);
        end
    endtask

    // Raster position index -> expected pin terms (before reset: idle values).
    function automatic void ref_model(input int pos, input int vv, input int vf,
                                      input int vsy, input int vb,
                                      output logic e_hs, output logic e_vs,
                                      output logic e_act, output int col, output int row);
        int vt;
        vt = vv + vf + vsy + vb;
        if (pos < 0) begin
            e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; col = 0; row = 0;
            return;
        end
        col   = pos % 800;
        row   = (pos / 800) % vt;
        e_hs  = !(col >= 656 && col <= 751);
        e_vs  = !(row >= vv + vf && row < vv + vf + vsy);
        e_act = (col < 640) && (row < vv);
    endfunction

    task automatic check_small();
        logic e_hs, e_vs, e_act;
        int col, row;
        ref_model(n - 3, S_VV, S_VF, S_VS, S_VB, e_hs, e_vs, e_act, col, row);
        check("s_hs",    int'(hs_s), int'(e_hs));
        check("s_vs",    int'(vs_s), int'(e_vs));
        check("s_blank", int'(bl_s), int'(e_act));
        check("s_red",   int'(r_s),  e_act ? col % 256 : 0);
        check("s_green", int'(g_s),  e_act ? row % 256 : 0);
        check("s_blue",  int'(b_s),  e_act ? 255 - col % 256 : 0);
        check("s_frame_start", int'(fs_s), (n > 0 && n % S_FRAME == 0) ? 1 : 0);
        check("m_frame_start", int'(fs_m), 0);
        if (fs_s) fs_cnt++;
        if (!hs_s) hs_run++;
        else if (hs_run != 0) begin
            check("s_hs_low_len", hs_run, 96);
            hs_run = 0;
        end
        if (!vs_s) vs_run++;
        else if (vs_run != 0) begin
            check("s_vs_low_len", vs_run, 1600);
            vs_run = 0;
        end
        fs_prev = fs_s;
    endtask

    // One pix_ce tick every other Clk; outputs sampled on the falling edge.
    task automatic do_tick();
        @(negedge clk);
        if (fs_prev) check("s_frame_start_width", int'(fs_s), 0);
        pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
        n++;
        check_small();
    endtask

    task automatic advance_to(input int target);
        while (n < target) do_tick();
    endtask

    task automatic check_main(input string tag, input int x, input int y, input logic hs,
                              input logic vs, input logic bl, input logic [7:0] r,
                              input logic [7:0] g, input logic [7:0] b);
        check({tag, "_x"},     int'(x_m),  x);
        check({tag, "_y"},     int'(y_m),  y);
        check({tag, "_hs"},    int'(hs_m), int'(hs));
        check({tag, "_vs"},    int'(vs_m), int'(vs));
        check({tag, "_blank"}, int'(bl_m), int'(bl));
        check({tag, "_r"},     int'(r_m),  int'(r));
        check({tag, "_g"},     int'(g_m),  int'(g));
        check({tag, "_b"},     int'(b_m),  int'(b));
    endtask

    typedef struct {
        int         n;
        int         x;
        int         y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // dut has PIPE_LAT = 1: pins after tick n show position n-2.
        vecs[0]  = '{1,   1,   0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{2,   2,   0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'h81};
        vecs[2]  = '{641, 641, 0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'h81};
        vecs[3]  = '{642, 642, 0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{657, 657, 0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{658, 658, 0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[6]  = '{753, 753, 0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{754, 754, 0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[8]  = '{800, 0,   1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[9]  = '{801, 1,   1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[10] = '{802, 2,   1, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'h81};

        rst_n  = 1'b0;
        pix_ce = 1'b0;
        psel   = 1'b0;
        psel_s = 1'b0;
        red_m  = 8'hA5;
        grn_m  = 8'h3C;
        blu_m  = 8'h81;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check_main("rst", 0, 0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        check("rst_sync_n", int'(sn_m), 0);
        check("rst_frame_start", int'(fs_m), 0);
        check("rst_s_x", int'(x_s), 0);
        check_small();
        rst_n = 1'b1;
        n = 0;

        // ---- table of hand-computed positions ----
        for (int i = 0; i < 11; i++) begin
            advance_to(vecs[i].n);
            check_main($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs,
                       vecs[i].bl, vecs[i].r, vecs[i].g, vecs[i].b);
        end

        // ---- pix_ce held low at hc = 639: everything frozen ----
        advance_to(1439);
        check_main("pre_hold", 639, 1, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'h81);
        repeat (100) @(negedge clk);
        check_main("hold", 639, 1, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'h81);
        check("hold_s_x", int'(x_s), 639);
        check_small();
        do_tick();
        check_main("post_hold", 640, 1, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'h81);

        // ---- asynchronous reset in the middle of a line ----
        advance_to(1900);
        check_main("pre_rst", 300, 2, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'h81);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        pix_ce = 1'b1;
        #1;
        check_main("mid_rst", 0, 0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        check("mid_rst_s_x", int'(x_s), 0);
        check("mid_rst_s_hs", int'(hs_s), 1);
        check("mid_rst_s_blank", int'(bl_s), 0);
        repeat (3) @(negedge clk);
        pix_ce = 1'b0;
        check("mid_rst_held_x", int'(x_m), 0);
        rst_n   = 1'b1;
        n       = 0;
        fs_cnt  = 0;
        hs_run  = 0;
        vs_run  = 0;
        fs_prev = 1'b0;
        do_tick();
        check_main("rel_rst", 1, 0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

        // ---- free run across two short frames (per-tick model on dut_s) ----
        advance_to(9700);
        check("frame_start_count", fs_cnt, 2);
        check_main("run_end", 9700 % 800, 9700 / 800, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'h81);

`ifdef VGA_TEST_PATTERN_EN
        // ---- colour bars: line 13 starts at tick 10400 ----
        psel = 1'b1;
        advance_to(10402);
        check_main("bar0", 2, 13, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        advance_to(10482);
        check_main("bar1", 82, 13, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF);
        advance_to(10962);
        check_main("bar7", 562, 13, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
        advance_to(11042);
        check_main("bar_blank", 642, 13, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        psel = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
